// File: rtl/gray_img_server.sv
// gray_img_server: memory-side responder for an LBP engine.
// Loads a 128x128 gray image from a streaming port, serves one-cycle-latency
// reads, sinks LBP result writes into a buffer with a saturating write count,
// and offers registered readback of the results.
// Optional build macro: LBP_BORDER_CHECK_EN drops result writes that land on
// the image border and raises a sticky err flag for them.
module gray_img_server #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          gray_ready,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic [AW-1:0] lbp_count,
    output logic          err
);

    localparam int unsigned DEPTH     = IMG_W * IMG_H;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] load_ptr;
    logic          load_last;
    logic          load_fire;
    logic          lbp_take;
    logic          lbp_border;
    logic          lbp_wr;

    logic [DW-1:0] gray_mem [0:DEPTH-1];
    logic [DW-1:0] lbp_mem  [0:DEPTH-1];

    assign load_fire  = load_valid & load_ready & (state == ST_LOAD);
    assign gray_ready = (state == ST_SERVE);
    assign done       = (state == ST_DONE);
    assign lbp_take   = lbp_valid & (state == ST_SERVE);
    assign lbp_wr     = lbp_take & ~lbp_border;

`ifdef LBP_BORDER_CHECK_EN
    localparam int CW = AW / 2;
    localparam int RW = AW - CW;

    logic [RW-1:0] lbp_row;
    logic [CW-1:0] lbp_col;

    assign lbp_row    = lbp_addr[AW-1:CW];
    assign lbp_col    = lbp_addr[CW-1:0];
    assign lbp_border = (lbp_row == '0) || (lbp_row == RW'(IMG_H - 1)) ||
                        (lbp_col == '0) || (lbp_col == CW'(IMG_W - 1));

    // Sticky flag for result writes that were dropped on the border
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (lbp_take && lbp_border) begin
            err <= 1'b1;
        end
    end
`else
    assign lbp_border = 1'b0;
    assign err        = 1'b0;
`endif

    // Phase control: load pointer, load handshake and LOAD -> SERVE -> DONE.
    // The last accepted pixel drops load_ready at once; SERVE follows one
    // cycle later via load_last so gray_ready trails load_ready by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOAD;
            load_ptr   <= '0;
            load_ready <= 1'b0;
            load_last  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_last) begin
                        state <= ST_SERVE;
                    end else begin
                        load_ready <= 1'b1;
                        if (load_fire) begin
                            load_ptr <= load_ptr + 1'b1;
                            if (load_ptr == LAST_PTR) begin
                                load_ready <= 1'b0;
                                load_last  <= 1'b1;
                            end
                        end
                    end
                end
                ST_SERVE: begin
                    if (finish) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // Image storage, written only by accepted load pixels
    always_ff @(posedge clk) begin
        if (load_fire) begin
            gray_mem[load_ptr] <= load_data;
        end
    end

    // Registered image read; holds its value unless a SERVE-phase request arrives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray_data <= '0;
        end else if (gray_req && (state == ST_SERVE)) begin
            gray_data <= gray_mem[gray_addr];
        end
    end

    // Result buffer, written by accepted SERVE-phase result writes
    always_ff @(posedge clk) begin
        if (lbp_wr) begin
            lbp_mem[lbp_addr] <= lbp_data;
        end
    end

    // Saturating count of accepted result writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lbp_count <= '0;
        end else if (lbp_wr && (lbp_count != '1)) begin
            lbp_count <= lbp_count + 1'b1;
        end
    end

    // Free-running registered readback of the result buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= lbp_mem[rd_addr];
        end
    end

endmodule

// File: doc/gray_img_server.md
Name: gray_img_server

Overview:
- Responder for the gray-image read interface and sink for the LBP result-write interface, i.e. the memory-side counterpart of the LBP engine.
- Loaded with a 128x128 8-bit image over a streaming load port, then raises gray_ready and serves gray_addr reads with one-cycle latency.
- Captures lbp_valid writes into a result buffer, counts them, and flags illegal addresses.
- Results can be read back after finish through a readback port.

Parameters:
- IMG_W, 128, image width in pixels (power of 2); address = {row, col}.
- IMG_H, 128, image height in pixels.
- AW, 14, address width, log2(IMG_W*IMG_H).
- DW, 8, pixel and LBP data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  load pixel present.
- load_data  in  DW  load pixel, raster order, address 0 first.
- load_ready  out  1  block accepts load pixels.
- gray_ready  out  1  image loaded; reads may be issued.
- gray_req  in  1  read request qualifier.
- gray_addr  in  AW  read address {row, col}.
- gray_data  out  DW  registered read data.
- lbp_valid  in  1  result write strobe.
- lbp_addr  in  AW  result write address.
- lbp_data  in  DW  result write data.
- finish  in  1  engine done.
- rd_addr  in  AW  readback address.
- rd_data  out  DW  registered readback data.
- done  out  1  finish has been seen.
- lbp_count  out  AW  number of accepted result writes.
- err  out  1  sticky illegal-write flag.

Behaviour:
- Reset (reset=0, async): state LOAD; load_ready=0, gray_ready=0, gray_data=0, rd_data=0, done=0, lbp_count=0, err=0, load pointer=0.
  - Memory arrays are not cleared and are untrusted after reset; the image must be reloaded.
  - Reset mid-LOAD or mid-SERVE aborts immediately with the same values.
- States: LOAD -> SERVE -> DONE. There is no exit from DONE except reset.
- LOAD:
  - load_ready=1 from the first cycle after reset release.
  - On load_valid&load_ready: gray_mem[ptr] <= load_data; ptr++.
  - When the pixel at ptr=IMG_W*IMG_H-1 is accepted: load_ready=0 and state goes to SERVE on the next edge.
  - gray_ready=1 in the first SERVE cycle.
  - load_valid while load_ready=0 is ignored.
- SERVE:
  - gray_ready=1.
  - If gray_req=1 at edge N, gray_data = gray_mem[gray_addr] is visible after edge N (consumer samples it at edge N+1).
  - gray_data holds its last value when gray_req=0.
  - A new address may be issued every cycle (full throughput).
  - gray_req outside SERVE: gray_data unchanged.
- Result writes (SERVE only): on lbp_valid=1, lbp_mem[lbp_addr] <= lbp_data and lbp_count++.
  - lbp_count saturates at all-ones.
  - Rewriting the same address overwrites the entry and still counts.
  - lbp_valid in LOAD or DONE is ignored and does not change the count.
- finish:
  - finish=1 in SERVE means state goes to DONE at the next edge; gray_ready=0 and done=1 from the next cycle.
  - An lbp_valid in the same cycle as finish is still written and counted.
  - finish in LOAD is ignored.
- Readback: rd_data <= lbp_mem[rd_addr] every cycle in any state, one-cycle latency. Valid only for addresses written since the last load.
- err is sticky until reset.
- Address arithmetic: row = addr[AW-1:AW/2], col = addr[AW/2-1:0], all unsigned.

Optional Feature:
- Macro LBP_BORDER_CHECK_EN.
- Defined:
  - An lbp_valid write whose row or col is 0 or IMG_W-1 (IMG_H-1 for row) is dropped: no memory write, no count, err=1 from the next cycle.
  - Any gray_req address is legal.
- Undefined:
  - Border writes are stored and counted like any other.
  - err is tied to 0.

Test Plan:
- Reset then load 16384 pixels with value = addr[7:0] -> load_ready falls after the last pixel; gray_ready=1 one cycle later; lbp_count=0.
- SERVE, gray_req=1 with gray_addr=0x0081 then 0x3FFF back-to-back -> gray_data=0x81 after the first edge and 0xFF after the second.
- lbp_valid writes to 0x0081=0xA5 and 0x0082=0x3C, then finish -> done=1; rd_addr=0x0081 gives rd_data=0xA5 next cycle; lbp_count=2.
- lbp_valid together with finish at 0x0100=0x11 -> entry written; lbp_count incremented; done=1 next cycle; later gray_req gives gray_data unchanged.
- With LBP_BORDER_CHECK_EN, write to 0x0000 -> err=1, lbp_count unchanged. Without the macro, the same write -> lbp_count+1, err=0.
- Assert reset mid-load at pixel 5000 -> all outputs return to reset values at once; a full reload then gives gray_ready=1.
